// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its IF/ID consumers.
//   XLEN              - datapath width
//   DEFAULT_RESET_PC  - PC loaded on reset
//   DEFAULT_NOP_INSTR - addi x0,x0,0, used to fill IF/ID on reset or flush
//   if_id_t           - IF/ID bundle layout, shared with id_stage
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            valid;
        logic            misaligned;
    } if_id_t;

    // Bubble contents: NOP, not valid, pc fields zeroed.
    function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
        if_id_t b;
        b.pc         = '0;
        b.pc_plus4   = '0;
        b.instr      = nop;
        b.valid      = 1'b0;
        b.misaligned = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: control from hazard unit / EX, instruction memory port and
// IF/ID outputs.
//   master - the fetch stage side (drives imem_addr and IF/ID outputs)
//   slave  - the surrounding pipeline / memory side
interface if_stage_if;
    import if_stage_pkg::*;

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_pc_plus4;
    logic [XLEN-1:0] if_id_instr;
    logic            if_id_valid;
    logic            if_id_misaligned;
    logic [XLEN-1:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_target, imem_instr,
        output imem_addr, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid,
               if_id_misaligned, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_target, imem_instr,
        input  imem_addr, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid,
               if_id_misaligned, fetch_count
    );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter with next-PC selection. Priority: redirect > stall > advance.
//   clk, reset       - clock, asynchronous active-high reset
//   stall            - hold PC
//   redirect         - load redirect_target
//   redirect_target  - new PC
//   pc_q             - current PC (always word-aligned)
//   misalign_q       - current PC came from a target with nonzero low bits
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_q,
    output logic            misalign_q
);

    logic [XLEN-1:0] pc_d;
    logic            misalign_d;

    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (redirect) begin
            // Store the aligned address so sequential fetches and the IF/ID pc
            // continue from the word boundary; the low bits only set the flag.
            pc_d       = {redirect_target[XLEN-1:2], 2'b00};
            misalign_d = |redirect_target[1:0];
        end else if (!stall) begin
            pc_d       = pc_q + 32'd4;
            misalign_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= {RESET_PC[XLEN-1:2], 2'b00};
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the fetch address, captures the returned
// instruction into the IF/ID register and counts delivered instructions.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - if_stage_if.master: stall/redirect control, imem port,
//                IF/ID outputs and fetch_count
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input logic          clk,
    input logic          reset,
    if_stage_if.master   bus
);

    logic [XLEN-1:0] pc_q;
    logic            misalign_q;
    if_id_t          if_id_q;
    if_id_t          if_id_d;
    logic [XLEN-1:0] fetch_count_q;
    logic [XLEN-1:0] fetch_count_d;

    if_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .reset           (reset),
        .stall           (bus.stall),
        .redirect        (bus.redirect),
        .redirect_target (bus.redirect_target),
        .pc_q            (pc_q),
        .misalign_q      (misalign_q)
    );

    assign bus.imem_addr = {pc_q[XLEN-1:2], 2'b00};

    always_comb begin
        if_id_d       = if_id_q;
        fetch_count_d = fetch_count_q;
        if (bus.redirect) begin
            if_id_d = if_id_bubble(NOP_INSTR);
        end else if (!bus.stall) begin
            if_id_d.pc         = pc_q;
            if_id_d.pc_plus4   = pc_q + 32'd4;
            if_id_d.instr      = bus.imem_instr;
            if_id_d.valid      = 1'b1;
            if_id_d.misaligned = misalign_q;
            fetch_count_d      = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_q       <= if_id_bubble(NOP_INSTR);
            fetch_count_q <= '0;
        end else begin
            if_id_q       <= if_id_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.if_id_pc         = if_id_q.pc;
    assign bus.if_id_pc_plus4   = if_id_q.pc_plus4;
    assign bus.if_id_instr      = if_id_q.instr;
    assign bus.if_id_valid      = if_id_q.valid;
    assign bus.if_id_misaligned = if_id_q.misaligned;
    assign bus.fetch_count      = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: each stimulus step pushes the hand-computed
// expected outputs; a monitor pops and compares on the next negedge (or on
// sample_ev for mid-cycle asynchronous reset checks).
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk;
    logic reset;

    if_stage_if bus ();

    if_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory stub.
    assign bus.imem_instr = 32'h1000_0000 | bus.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    event sample_ev;

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic push(input string name, input logic [31:0] addr, input logic [31:0] pc,
                        input logic [31:0] pc4, input logic [31:0] instr, input logic valid,
                        input logic mis, input logic [31:0] cnt);
        exp_t e;
        e.name = name; e.addr = addr; e.pc = pc; e.pc4 = pc4; e.instr = instr;
        e.valid = valid; e.mis = mis; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s got %h want %h", name, field, act, exp);
        end
    endtask

    // Monitor
    always begin
        @(negedge clk or sample_ev);
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "imem_addr", bus.imem_addr, e.addr);
            chk(e.name, "pc", bus.if_id_pc, e.pc);
            chk(e.name, "pc_plus4", bus.if_id_pc_plus4, e.pc4);
            chk(e.name, "instr", bus.if_id_instr, e.instr);
            chk(e.name, "valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
            chk(e.name, "misaligned", {31'd0, bus.if_id_misaligned}, {31'd0, e.mis});
            chk(e.name, "fetch_count", bus.fetch_count, e.cnt);
        end
    end

    // Drive inputs (called at a negedge), take one edge, then queue the expectation.
    task automatic step(input string name, input logic s, input logic r, input logic [31:0] t,
                        input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] instr, input logic valid, input logic mis,
                        input logic [31:0] cnt);
        bus.stall           = s;
        bus.redirect        = r;
        bus.redirect_target = t;
        @(posedge clk);
        #1;
        push(name, addr, pc, pc4, instr, valid, mis, cnt);
        @(negedge clk);
    endtask

    initial begin
        reset               = 1'b1;
        bus.stall           = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        push("reset", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Sequential fetch
        step("adv1", 0, 0, 0, 32'h4, 32'h0, 32'h4, 32'h1000_0000, 1, 0, 1);
        step("adv2", 0, 0, 0, 32'h8, 32'h4, 32'h8, 32'h1000_0004, 1, 0, 2);
        // Stall at pc=8
        for (int i = 0; i < 3; i++)
            step("stall", 1, 0, 0, 32'h8, 32'h4, 32'h8, 32'h1000_0004, 1, 0, 2);
        step("adv3", 0, 0, 0, 32'hC, 32'h8, 32'hC, 32'h1000_0008, 1, 0, 3);
        // Redirect to 0x40: one bubble, then target
        step("redir", 0, 1, 32'h40, 32'h40, 32'h0, 32'h0, NOP, 0, 0, 3);
        step("tgt40", 0, 0, 0, 32'h44, 32'h40, 32'h44, 32'h1000_0040, 1, 0, 4);
        // Stall and redirect together: redirect wins
        step("st_redir", 1, 1, 32'h80, 32'h80, 32'h0, 32'h0, NOP, 0, 0, 4);
        step("tgt80", 0, 0, 0, 32'h84, 32'h80, 32'h84, 32'h1000_0080, 1, 0, 5);
        // Misaligned target
        step("mis_redir", 0, 1, 32'h22, 32'h20, 32'h0, 32'h0, NOP, 0, 0, 5);
        step("mis_first", 0, 0, 0, 32'h24, 32'h20, 32'h24, 32'h1000_0020, 1, 1, 6);
        step("mis_next", 0, 0, 0, 32'h28, 32'h24, 32'h28, 32'h1000_0024, 1, 0, 7);
        // Back-to-back redirects
        step("b2b_a", 0, 1, 32'h200, 32'h200, 32'h0, 32'h0, NOP, 0, 0, 7);
        step("b2b_b", 0, 1, 32'h100, 32'h100, 32'h0, 32'h0, NOP, 0, 0, 7);
        step("tgt100", 0, 0, 0, 32'h104, 32'h100, 32'h104, 32'h1000_0100, 1, 0, 8);
        // PC wrap
        step("wrap_r", 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, NOP, 0, 0, 8);
        step("wrap_1", 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1, 0, 9);
        step("wrap_2", 0, 0, 0, 32'h4, 32'h0, 32'h4, 32'h1000_0000, 1, 0, 10);
        // Run at 0x100, then asynchronous reset mid-cycle
        step("run_r", 0, 1, 32'h100, 32'h100, 32'h0, 32'h0, NOP, 0, 0, 10);
        step("run_1", 0, 0, 0, 32'h104, 32'h100, 32'h104, 32'h1000_0100, 1, 0, 11);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        push("async_rst", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        ->sample_ev;
        @(posedge clk);
        #1;
        push("rst_hold", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("post_rst", 0, 0, 0, 32'h4, 32'h0, 32'h4, 32'h1000_0000, 1, 0, 1);

        // Drain scoreboard with a bound
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
